// File: rtl/seq_restoring_divider_if.sv
// ============================================================================
//  Module   : seq_restoring_divider_if
//  Brief    : Start/operand/result bundle for the sequential restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_restoring_divider_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
//  Module   : seq_restoring_divider
//  Brief    : Unsigned N/M restoring divider, one quotient bit per clock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus
);

    localparam int c_CNT_W = $clog2(N + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_zero;
    logic                 w_step;
    logic                 w_last;

    logic [N-1:0]         r_work;
    logic [M-1:0]         r_div;
    logic [M:0]           r_part;
    logic [c_CNT_W-1:0]   r_count;
    logic [N-1:0]         r_quot;
    logic [M-1:0]         r_rem;
    logic                 r_dbz;
    logic                 r_done;

    logic [M:0]           w_shift;
    logic [M:0]           w_trial;
    logic [M:0]           w_part_next;
    logic [N-1:0]         w_work_next;
    logic                 w_qbit;

    // The working register doubles as the quotient accumulator: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    always_comb begin
        w_shift     = (r_part << 1) | {{M{1'b0}}, r_work[N-1]};
        w_trial     = w_shift - {1'b0, r_div};
        w_qbit      = ~w_trial[M];
        w_part_next = w_qbit ? w_trial : w_shift;
        w_work_next = {r_work[N-2:0], w_qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_zero       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        w_accept     = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        w_zero = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_count == c_CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_div   <= '0;
            r_part  <= '0;
            r_count <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last | w_zero;
            if (w_accept) begin
                r_work  <= bus.dividend;
                r_div   <= bus.divisor;
                r_part  <= '0;
                r_count <= c_CNT_W'(N);
            end
            if (w_zero) begin
                r_quot <= '1;
                r_rem  <= '0;
                r_dbz  <= 1'b1;
            end
            if (w_step) begin
                r_work  <= w_work_next;
                r_part  <= w_part_next;
                r_count <= r_count - c_CNT_W'(1);
                // Results are only published on the final step so they stay
                // stable for the whole of the next division.
                if (w_last) begin
                    r_quot <= w_work_next;
                    r_rem  <= w_part_next[M-1:0];
                    r_dbz  <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
//  Module   : tb_seq_restoring_divider
//  Brief    : Directed and exhaustive self-checking bench for the divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_restoring_divider_if #(.N(8), .M(4)) bus ();

    seq_restoring_divider #(.N(8), .M(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int a, input int b);
        bus.dividend = 8'(a);
        bus.divisor  = 4'(b);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    // Counts edges until done is seen; flags any cycle with busy and done together.
    task automatic wait_done(input int limit, output int ticks, output bit ok, output bit clash);
        ticks = 0;
        ok    = 1'b0;
        clash = 1'b0;
        while (ticks < limit) begin
            tick();
            ticks++;
            if (bus.busy && bus.done) clash = 1'b1;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, required all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic;
        launch(200, 7);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 8'd0) begin
                n_err++;
                $display("FAIL basic_run cycle %0d: got busy=%b done=%b q=%0d, required 1 0 0",
                         i, bus.busy, bus.done, bus.quotient);
            end
            tick();
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: got done=%b busy=%b, required 1 0", bus.done, bus.busy);
        end
        n_cmp++;
        if (bus.quotient !== 8'd28 || bus.remainder !== 4'd4 || bus.div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, required 28 4 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pulse: got done=%b, required 0", bus.done);
        end
    endtask

    task automatic test_back_to_back;
        int t;
        bit ok;
        bit clash;
        launch(255, 15);
        wait_done(20, t, ok, clash);
        n_cmp++;
        if (!ok || t != 8) begin
            n_err++;
            $display("FAIL b2b_first_latency: got ok=%b edges=%0d, required 1 8", ok, t);
        end
        n_cmp++;
        if (bus.quotient !== 8'd17 || bus.remainder !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_first_result: got q=%0d r=%0d, required 17 0", bus.quotient, bus.remainder);
        end
        launch(5, 9);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 8'd17) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b done=%b q=%0d, required 1 0 17",
                     bus.busy, bus.done, bus.quotient);
        end
        wait_done(20, t, ok, clash);
        n_cmp++;
        if (!ok || t + 1 != 9 || clash) begin
            n_err++;
            $display("FAIL b2b_second_latency: got ok=%b cycles=%0d clash=%b, required 1 9 0", ok, t + 1, clash);
        end
        n_cmp++;
        if (bus.quotient !== 8'd0 || bus.remainder !== 4'd5) begin
            n_err++;
            $display("FAIL b2b_second_result: got q=%0d r=%0d, required 0 5", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero;
        tick();
        launch(123, 0);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_done: got done=%b busy=%b, required 1 0", bus.done, bus.busy);
        end
        n_cmp++;
        if (bus.quotient !== 8'd255 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b, required 255 0 1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 8'd255 || bus.div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_hold: got done=%b busy=%b q=%0d dbz=%b, required 0 0 255 1",
                     bus.done, bus.busy, bus.quotient, bus.div_by_zero);
        end
    endtask

    task automatic test_ignore_start;
        int t;
        bit ok;
        bit clash;
        launch(100, 3);
        tick();
        tick();
        tick();
        launch(50, 5);
        wait_done(20, t, ok, clash);
        n_cmp++;
        if (!ok || t != 4) begin
            n_err++;
            $display("FAIL ignore_latency: got ok=%b edges=%0d, required 1 4", ok, t);
        end
        n_cmp++;
        if (bus.quotient !== 8'd33 || bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: got q=%0d r=%0d dbz=%b, required 33 1 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.busy || bus.done) ok = 1'b1;
        end
        n_cmp++;
        if (ok) begin
            n_err++;
            $display("FAIL ignore_no_queue: got activity=1, required 0");
        end
    endtask

    task automatic test_reset_abort;
        int t;
        bit ok;
        bit clash;
        launch(100, 3);
        tick();
        tick();
        tick();
        launch(50, 5);
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 15'h0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, required all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.busy || bus.done) ok = 1'b1;
        end
        n_cmp++;
        if (ok) begin
            n_err++;
            $display("FAIL abort_no_done: got activity=1, required 0");
        end
        launch(100, 3);
        wait_done(20, t, ok, clash);
        n_cmp++;
        if (!ok || t != 8 || bus.quotient !== 8'd33 || bus.remainder !== 4'd1) begin
            n_err++;
            $display("FAIL abort_fresh: got ok=%b edges=%0d q=%0d r=%0d, required 1 8 33 1",
                     ok, t, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_sweep;
        int t;
        int gap;
        int exp_q;
        int exp_r;
        int exp_t;
        bit exp_z;
        bit ok;
        bit clash;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) tick();
                exp_q = (b == 0) ? 255 : a / b;
                exp_r = (b == 0) ? 0 : a % b;
                exp_z = (b == 0);
                exp_t = (b == 0) ? 0 : 8;
                launch(a, b);
                if (bus.done) begin
                    t     = 0;
                    ok    = 1'b1;
                    clash = bus.busy;
                end else begin
                    wait_done(20, t, ok, clash);
                end
                n_cmp++;
                if (!ok || t != exp_t || clash) begin
                    n_err++;
                    $display("FAIL sweep_timing %0d/%0d: got ok=%b edges=%0d clash=%b, required 1 %0d 0",
                             a, b, ok, t, clash, exp_t);
                end
                n_cmp++;
                if (bus.quotient !== 8'(exp_q) || bus.remainder !== 4'(exp_r) || bus.div_by_zero !== exp_z) begin
                    n_err++;
                    $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%b, required %0d %0d %b",
                             a, b, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, exp_z);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 SHALL have parameter N, default 8: dividend and quotient width in bits.
REQ-002 SHALL have parameter M, default 4: divisor and remainder width in bits; M <= N.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a division; sampled on the rising edge.
REQ-007 dividend  input  N  unsigned dividend; sampled only on the edge that accepts start.
REQ-008 divisor  input  M  unsigned divisor; sampled only on the edge that accepts start.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-011 quotient  output  N  unsigned quotient, registered.
REQ-012 remainder  output  M  unsigned remainder, registered.
REQ-013 div_by_zero  output  1  registered flag; high when the last completed division had divisor 0.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-015 IDLE, start=1, divisor!=0 -> RUN at that edge:
- latch the dividend into a working register;
- latch the divisor;
- clear the (M+1)-bit partial remainder;
- load the iteration counter with N;
- set busy=1.
REQ-016 RUN, each cycle, one restoring step:
- shift {partial remainder, dividend MSB} left;
- compute trial = partial - divisor, at M+1 bits;
- if trial is non-negative, keep trial and shift in quotient bit 1;
- otherwise keep partial and shift in quotient bit 0;
- decrement the counter.
REQ-017 On the edge that completes the Nth step:
- load quotient and remainder;
- set done=1 for exactly one cycle;
- set busy=0, div_by_zero=0;
- return to IDLE.
REQ-018 Latency: start accepted at edge t0 -> done high in the cycle after edge t0+N (N cycles; 8 at default).
REQ-019 IDLE, start=1, divisor==0, at the accepting edge:
- quotient = all ones;
- remainder = 0;
- div_by_zero = 1;
- done = 1 in the next cycle;
- busy stays 0;
- FSM stays in IDLE.
REQ-020 start while busy=1 SHALL be ignored; operands are not re-sampled and timing is not disturbed.
REQ-021 start in the same cycle that done=1 SHALL be accepted, giving back-to-back divisions every N+1 cycles.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values until the next done; they SHALL NOT change during RUN.
REQ-023 Results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
REQ-024 The partial remainder SHALL be M+1 bits wide so the trial subtraction never overflows.
REQ-025 done and busy SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 SHALL immediately force the following, independent of clk:
- FSM = IDLE;
- busy = 0, done = 0;
- quotient = 0, remainder = 0, div_by_zero = 0;
- counter and working registers = 0.
REQ-027 rst asserted during RUN SHALL abort the division; no done is produced for it.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 Dividend 200, divisor 7, start pulse -> busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
REQ-030 Dividend 255, divisor 15 -> quotient=17, remainder=0; then immediately 5/9, start asserted during done -> quotient=0, remainder=5, 9 cycles after the first done.
REQ-031 Dividend 123, divisor 0 -> done in the next cycle with quotient=255, remainder=0, div_by_zero=1, busy never high.
REQ-032 Start 100/3, pulse start again with 50/5 at cycle 4, then assert rst at cycle 6 -> outputs 0 immediately, no done; a fresh 100/3 then gives quotient=33, remainder=1.
REQ-033 Exhaustive sweep of all 256 dividends x 16 divisors with random inter-start gaps -> every result matches a reference model, and done follows the accepting edge by exactly 8 cycles (1 cycle for divisor 0).
